// File: rtl/uart_rx_sampler.sv
`timescale 1ns/1ps
// 8N1 serial receiver: synchronises uart_rx, samples at 16x oversampling and
// presents each correctly framed byte with a one-clock rx_status strobe.
module uart_rx_sampler #(
    parameter int BAUD_DIV    = 651,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    state_t      state_q;
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic        div_run;
    logic        tick;
    logic [3:0]  tcnt_q;
    logic [2:0]  bcnt_q;
    logic [7:0]  shreg_q;
    logic [7:0]  rx_data_q;
    logic        rx_status_q;
    logic        frame_err_q;
    logic        busy_q;

    // Synchroniser flops reset to 1 so the idle-high line never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Divider only runs while a frame is being sampled, so tick phase follows the start edge.
    assign div_run = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign tick    = div_run && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + 16'd1;
        if (!div_run || tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_status_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: strobes default low every clock and are only raised by the
            // transition that produces them, which guarantees one-clock pulses.
            rx_status_q <= 1'b0;
            frame_err_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (!rxs) begin
                        state_q <= S_START;
                        tcnt_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (tcnt_q == 4'd7) begin
                            if (rxs) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                tcnt_q  <= '0;
                                bcnt_q  <= '0;
                                state_q <= S_DATA;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + 4'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            shreg_q <= {rxs, shreg_q[7:1]};
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) begin
                                state_q <= S_STOP;
                            end
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            if (rxs) begin
                                rx_data_q   <= shreg_q;
                                rx_status_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= S_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end
                        end
                    end
                end

                S_BREAK: begin
                    // A held-low line must go high before another start edge can be seen.
                    if (rxs) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_status = rx_status_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
`timescale 1ns/1ps
// Bench for uart_rx_sampler: directed frames on a fast-divider instance checked
// against a frame-level expectation queue, plus a 2%-fast transmitter case.
module tb_uart_rx_sampler;

    localparam int BIT_A = 64;   // 16 ticks * BAUD_DIV 4
    localparam int BIT_B = 627;  // 16 * 40 = 640 nominal, transmitter 2% fast

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;
    logic       busy;
    logic [7:0] rx_data_b;
    logic       rx_status_b;
    logic       frame_err_b;
    logic       busy_b;

    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    exp_t       cmp_e;
    int         status_at[$];
    logic [7:0] status_dat[$];
    int         err_at[$];
    logic [7:0] model_data  = 8'h00;
    logic       prev_status = 1'b0;
    logic       prev_err    = 1'b0;
    int         low_run     = 0;
    int         last_gap    = 0;
    int         b_status    = 0;
    int         b_err       = 0;

    uart_rx_sampler #(.BAUD_DIV(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (rx_a),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .frame_err (frame_err),
        .busy      (busy)
    );

    uart_rx_sampler #(.BAUD_DIV(40), .SYNC_STAGES(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (rx_b),
        .rx_data   (rx_data_b),
        .rx_status (rx_status_b),
        .frame_err (frame_err_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, away from DUT sampling.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop, output int start);
        exp_t e;
        e.err  = ~stop;
        e.data = d;
        exp_q.push_back(e);
        rx_a  = 1'b0;
        start = cyc;
        step(BIT_A);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            step(BIT_A);
        end
        rx_a = stop;
        step(BIT_A);
    endtask

    task automatic send_b(input logic [7:0] d, input int bitlen);
        rx_b = 1'b0;
        step(bitlen);
        for (int i = 0; i < 8; i++) begin
            rx_b = d[i];
            step(bitlen);
        end
        rx_b = 1'b1;
        step(bitlen);
    endtask

    // Frame-level model: every pulse must match the next queued frame outcome,
    // and rx_data must always hold the most recent good byte.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_data  = 8'h00;
            prev_status = 1'b0;
            prev_err    = 1'b0;
            low_run     = 0;
            check("reset_rx_data", rx_data, 8'h00);
            check("reset_pulses", {rx_status, frame_err}, 2'b00);
            check("reset_busy", busy, 1'b0);
        end else begin
            check("pulse_exclusive", rx_status & frame_err, 1'b0);
            check("status_width", prev_status & rx_status, 1'b0);
            check("err_width", prev_err & frame_err, 1'b0);
            if (rx_status || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {rx_status, frame_err}, 2'b00);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("pulse_kind", frame_err, cmp_e.err);
                    if (!cmp_e.err) begin
                        check("pulse_data", rx_data, cmp_e.data);
                        model_data = cmp_e.data;
                    end
                end
                if (rx_status) begin
                    status_at.push_back(cyc);
                    status_dat.push_back(rx_data);
                end
                if (frame_err) err_at.push_back(cyc);
            end
            check("rx_data_held", rx_data, model_data);
            if (!busy) begin
                low_run++;
            end else begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
            end
            prev_status = rx_status;
            prev_err    = frame_err;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_status_b) b_status++;
            if (frame_err_b) b_err++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         p;
        int         p2;
        int         fall;
        logic [7:0] v81;
        v81 = 8'h81;

        #2 reset = 1'b1;
        step(5);
        reset = 1'b0;
        step(5);
        check("init_rx_data", rx_data, 8'h00);
        check("init_busy", busy, 1'b0);
        check("init_pulses", {rx_status, frame_err}, 2'b00);

        // 0x55, good stop: pulse 608 clk after rxs falls, 610 after the pin edge.
        send_a(8'h55, 1'b1, p);
        check("t55_count", status_at.size(), 1);
        if (status_at.size() > 0) check_range("t55_latency", status_at[0] - p, 609, 611);
        check("t55_data", rx_data, 8'h55);
        check("t55_no_err", err_at.size(), 0);
        step(32);

        // 20-clk low glitch: rejected at the mid-start sample.
        rx_a = 1'b0;
        p    = cyc;
        step(20);
        rx_a = 1'b1;
        step(10);
        check("glitch_busy_mid", busy, 1'b1);
        fall = -1;
        for (int i = 0; i < 60 && fall < 0; i++) begin
            @(negedge clk);
            if (!busy) fall = cyc;
        end
        check_range("glitch_busy_fall", fall - p, 33, 37);
        check("glitch_no_status", status_at.size(), 1);
        check("glitch_no_err", err_at.size(), 0);
        step(20);

        // 0xFF with low stop bit, line held low: one frame_err, data kept.
        send_a(8'hFF, 1'b0, p);
        check("brk_err_count", err_at.size(), 1);
        if (err_at.size() > 0) check_range("brk_err_latency", err_at[0] - p, 609, 611);
        check("brk_data_kept", rx_data, 8'h55);
        step(500);
        check("brk_busy_held", busy, 1'b1);
        check("brk_single_err", err_at.size(), 1);
        check("brk_no_status", status_at.size(), 1);
        rx_a = 1'b1;
        step(6);
        check("brk_busy_release", busy, 1'b0);
        step(64);
        send_a(8'h3C, 1'b1, p);
        check("t3c_data", rx_data, 8'h3C);
        check("t3c_count", status_at.size(), 2);
        step(32);

        // Reset in the middle of data bit 4 of 0x81.
        rx_a = 1'b0;
        step(BIT_A);
        for (int i = 0; i < 4; i++) begin
            rx_a = v81[i];
            step(BIT_A);
        end
        rx_a = v81[4];
        step(BIT_A / 2);
        reset = 1'b1;
        rx_a  = 1'b1;
        step(4);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        step(40);
        check("rst_idle_busy", busy, 1'b0);
        check("rst_no_pulse", status_at.size() + err_at.size(), 3);
        send_a(8'h81, 1'b1, p);
        check("t81_data", rx_data, 8'h81);
        check("t81_count", status_at.size(), 3);
        step(32);

        // Back-to-back 0xA3, 0x00 with a single stop bit.
        send_a(8'hA3, 1'b1, p);
        send_a(8'h00, 1'b1, p2);
        check("b2b_count", status_at.size(), 5);
        if (status_at.size() == 5) begin
            check("b2b_spacing", status_at[4] - status_at[3], 640);
            check_range("b2b_latency", status_at[3] - p, 609, 611);
            check("b2b_first", status_dat[3], 8'hA3);
            check("b2b_second", status_dat[4], 8'h00);
        end
        check_range("b2b_busy_gap", last_gap, 1, 32);
        check("b2b_data", rx_data, 8'h00);
        step(32);

        // Larger divider, transmitter running 2% fast.
        send_b(8'h7E, BIT_B);
        step(100);
        check("fast_status_count", b_status, 1);
        check("fast_data", rx_data_b, 8'h7E);
        check("fast_no_err", b_err, 0);

        check("pending_frames", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
